// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: mux selects, FSM states, parity types.
package uart_pkg;

    localparam logic [1:0] SEL_START  = 2'd0;
    localparam logic [1:0] SEL_DATA   = 2'd1;
    localparam logic [1:0] SEL_PARITY = 2'd2;
    localparam logic [1:0] SEL_STOP   = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // IDLE and STOP both hold the line high, so they share the stop select.
    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_DATA;
            ST_PARITY: return SEL_PARITY;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of a data word: even = XOR-reduce, odd = its inverse.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    assign parity = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: latches a word, then walks start/data/parity/stop
// one bit per baud clock while driving the TX mux select.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  serial_data,
    output logic                  parity_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    par_en_q;
    logic                    par_calc;
    logic                    accept;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .parity  (par_calc)
    );

    // STOP accepts too, so a held request chains frames without an idle gap.
    always_comb begin
        accept     = DATA_VALID && (state == ST_IDLE || state == ST_STOP);
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_START;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   if (bit_cnt == LAST_BIT) next_state = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: next_state = ST_STOP;
            ST_STOP:   next_state = accept ? ST_START : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they line up with the state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            mux_sel <= SEL_STOP;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            mux_sel <= sel_of(next_state);
            busy    <= (next_state != ST_IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            if (accept) begin
                shreg      <= P_DATA;
                par_en_q   <= PAR_EN;
                parity_bit <= par_calc;
            end else if (state == ST_DATA) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_START)
                bit_cnt <= '0;
        end
    end

    assign serial_data = shreg[0];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: per-cycle expected mux/busy/data/parity records.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [1:0] mux_sel;
    logic       serial_data, parity_bit, busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       bsy;
        logic       chk_sd;
        logic       sd;
        logic       chk_par;
        logic       par;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .DATA_VALID  (DATA_VALID),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .mux_sel     (mux_sel),
        .serial_data (serial_data),
        .parity_bit  (parity_bit),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic model_par(input logic [7:0] d, input logic typ);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return ((ones % 2) == 1) ^ typ;
    endfunction

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        logic p;
        p = model_par(d, pt);
        sb.push_back('{2'd0, 1'b1, 1'b0, 1'b0, 1'b1, p});
        for (int i = 0; i < 8; i++) sb.push_back('{2'd1, 1'b1, 1'b1, d[i], 1'b1, p});
        if (pe) sb.push_back('{2'd2, 1'b1, 1'b0, 1'b0, 1'b1, p});
        sb.push_back('{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, p});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back('{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    // Present a request just after a rising edge; returns after the accepting edge.
    task automatic request(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            compared++;
            if (mux_sel !== 2'd3 || busy !== 1'b0 || serial_data !== 1'b0 || parity_bit !== 1'b0) begin
                mismatched++;
                $display("FAIL reset cyc%0d: sel=%0d busy=%b sd=%b par=%b want sel=3 busy=0 sd=0 par=0",
                         i, mux_sel, busy, serial_data, parity_bit);
            end
        end
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            compared++;
            if (mux_sel !== 2'd3 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_release cyc%0d: sel=%0d busy=%b want sel=3 busy=0", i, mux_sel, busy);
            end
        end
    endtask

    task automatic test_parity_frame;
        push_frame(8'hA5, 1'b1, 1'b0);
        push_idle(2);
        request(8'hA5, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front();
            compared++;
            if (mux_sel !== e.sel || busy !== e.bsy || (e.chk_sd && serial_data !== e.sd) ||
                (e.chk_par && parity_bit !== e.par)) begin
                mismatched++;
                $display("FAIL a5_even cyc%0d: sel=%0d busy=%b sd=%b par=%b want sel=%0d busy=%b sd=%b par=%b",
                         k, mux_sel, busy, serial_data, parity_bit, e.sel, e.bsy, e.sd, e.par);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_odd_noparity;
        push_frame(8'h01, 1'b1, 1'b1);
        push_idle(1);
        push_frame(8'h01, 1'b0, 1'b1);
        push_idle(2);
        request(8'h01, 1'b1, 1'b1);
        DATA_VALID = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front();
            compared++;
            if (mux_sel !== e.sel || busy !== e.bsy || (e.chk_sd && serial_data !== e.sd) ||
                (e.chk_par && parity_bit !== e.par)) begin
                mismatched++;
                $display("FAIL odd_nopar cyc%0d: sel=%0d busy=%b sd=%b par=%b want sel=%0d busy=%b sd=%b par=%b",
                         k, mux_sel, busy, serial_data, parity_bit, e.sel, e.bsy, e.sd, e.par);
            end
            // Second request goes in during the idle cycle after the first frame.
            if (k == 11) begin P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b1; DATA_VALID = 1'b1; end
            if (k == 12) DATA_VALID = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back;
        push_frame(8'h3C, 1'b1, 1'b0);
        push_frame(8'hFF, 1'b1, 1'b1);
        push_idle(2);
        request(8'h3C, 1'b1, 1'b0);
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front();
            compared++;
            if (mux_sel !== e.sel || busy !== e.bsy || (e.chk_sd && serial_data !== e.sd) ||
                (e.chk_par && parity_bit !== e.par)) begin
                mismatched++;
                $display("FAIL b2b cyc%0d: sel=%0d busy=%b sd=%b par=%b want sel=%0d busy=%b sd=%b par=%b",
                         k, mux_sel, busy, serial_data, parity_bit, e.sel, e.bsy, e.sd, e.par);
            end
            if (k == 10) begin P_DATA = 8'hFF; PAR_TYP = 1'b1; end
            if (k == 11) DATA_VALID = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_ignored_request;
        push_frame(8'hC3, 1'b1, 1'b1);
        push_idle(4);
        request(8'hC3, 1'b1, 1'b1);
        DATA_VALID = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front();
            compared++;
            if (mux_sel !== e.sel || busy !== e.bsy || (e.chk_sd && serial_data !== e.sd) ||
                (e.chk_par && parity_bit !== e.par)) begin
                mismatched++;
                $display("FAIL ignored_req cyc%0d: sel=%0d busy=%b sd=%b par=%b want sel=%0d busy=%b sd=%b par=%b",
                         k, mux_sel, busy, serial_data, parity_bit, e.sel, e.bsy, e.sd, e.par);
            end
            if (k == 3) begin P_DATA = 8'h55; PAR_TYP = 1'b0; PAR_EN = 1'b0; DATA_VALID = 1'b1; end
            if (k == 4) DATA_VALID = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_midframe;
        request(8'hE7, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        // Now in the 4th DATA cycle; reset lands between edges.
        #2 RST = 1'b0;
        #1;
        compared++;
        if (mux_sel !== 2'd3 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midframe_async: sel=%0d busy=%b want sel=3 busy=0", mux_sel, busy);
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        push_idle(2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (mux_sel !== e.sel || busy !== e.bsy) begin
                mismatched++;
                $display("FAIL midframe_idle: sel=%0d busy=%b want sel=%0d busy=%b", mux_sel, busy, e.sel, e.bsy);
            end
            @(posedge CLK); #1;
        end
        push_frame(8'h0F, 1'b0, 1'b0);
        push_idle(2);
        request(8'h0F, 1'b0, 1'b0);
        DATA_VALID = 1'b0;
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front();
            compared++;
            if (mux_sel !== e.sel || busy !== e.bsy || (e.chk_sd && serial_data !== e.sd) ||
                (e.chk_par && parity_bit !== e.par)) begin
                mismatched++;
                $display("FAIL after_reset cyc%0d: sel=%0d busy=%b sd=%b par=%b want sel=%0d busy=%b sd=%b par=%b",
                         k, mux_sel, busy, serial_data, parity_bit, e.sel, e.bsy, e.sd, e.par);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        test_reset;
        test_parity_frame;
        test_odd_noparity;
        test_back_to_back;
        test_ignored_request;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
